nes_mem_arbiter: RTL

Parametrised successor to the NES single-port memory controller. Time-slices one external byte-wide ROM/RAM port among NCH requesters (CPU, PPU, loader, DMA…) with round-robin arbitration.
- Provides per-channel request/ack handshakes and per-channel read-data registers.
- Applies iNES address translation: header skip plus CHR base offset.
- Generates the run_mem/run_nes phase strobes used by the rest of the NES core.

---
 rtl/nes_mem_pkg.sv | 53 +++++
 rtl/nes_rr_arbiter.sv | 44 ++++
 rtl/nes_mem_arbiter.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/nes_mem_pkg.sv
// -----------------------------------------------------------------------------
// nes_mem_pkg
// Shared definitions for the NES memory arbiter and the ROM loader.
//   HDR_BYTES_DEF / CHR_SHIFT_DEF : default iNES translation constants
//   clog2()    : ceiling log2, usable in constant expressions
//   nes_xlat() : iNES address translation (header skip + CHR base offset)
// -----------------------------------------------------------------------------
package nes_mem_pkg;

  localparam int HDR_BYTES_DEF = 16;
  localparam int CHR_SHIFT_DEF = 14;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // iNES translation on a zero-extended address of width aw (aw <= 32).
  // Bit aw-1 selects CHR space; the remaining bits are the offset in that
  // space. CHR data starts after chr_offset[6:0] PRG banks. The caller
  // truncates the result to aw bits, so any carry out is dropped.
  function automatic logic [31:0] nes_xlat(
    input logic [31:0] addr,
    input logic [7:0]  chr_offset,
    input logic        en,
    input int          aw,
    input int          hdr_bytes,
    input int          chr_shift
  );
    logic [31:0] low;
    logic [31:0] chr_base;
    logic [31:0] res;
    low      = addr & ((32'd1 << (aw - 1)) - 32'd1);
    chr_base = {24'd0, chr_offset & 8'h7F} << chr_shift;
    if (!en) begin
      res = addr;
    end else if (addr[aw-1]) begin
      res = low + chr_base + 32'(hdr_bytes);
    end else begin
      res = low + 32'(hdr_bytes);
    end
    return res;
  endfunction

endpackage

// File: rtl/nes_rr_arbiter.sv
// -----------------------------------------------------------------------------
// nes_rr_arbiter
// Combinational round-robin picker. Scans i_req starting at i_ptr and wraps
// round to find the first request. The pointer register is held in the parent.
//   i_req       : NCH request vector
//   i_ptr       : channel with highest priority this round
//   o_grant     : one-hot grant (all zero when nothing is requested)
//   o_grant_idx : index of the granted channel
//   o_any       : at least one request was granted
// -----------------------------------------------------------------------------
module nes_rr_arbiter
  import nes_mem_pkg::*;
#(
  parameter int NCH = 2,
  parameter int PW  = 1
) (
  input  logic [NCH-1:0] i_req,
  input  logic [PW-1:0]  i_ptr,
  output logic [NCH-1:0] o_grant,
  output logic [PW-1:0]  o_grant_idx,
  output logic           o_any
);

  int w_idx;

  // First-set search from the pointer, with wrap-around
  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any       = 1'b0;
    w_idx       = 0;
    for (int k = 0; k < NCH; k++) begin
      w_idx = (int'(i_ptr) + k) % NCH;
      if (!o_any && i_req[w_idx]) begin
        o_any          = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_grant_idx    = PW'(w_idx);
      end else begin
        // earlier channel already won, or this one is idle
      end
    end
  end

endmodule

// File: rtl/nes_mem_arbiter.sv
// -----------------------------------------------------------------------------
// nes_mem_arbiter
// Time-slices one byte-wide external memory port among NCH requesters with
// round-robin arbitration. One slot = SLOT_CYCLES clocks; the access is driven
// during phase 0 and completes (read data sampled) at the last phase.
//   clk, reset          : clock, synchronous active-high reset
//   run_mem / run_nes   : phase strobes (phase 0 / last phase)
//   xlat_en, chr_offset : iNES address translation controls
//   req_valid/ready/write/addr/wdata : per-channel request handshake
//   ack, rd_data        : per-channel completion pulse and last read byte
//   mem_ce/we/addr/do/di: external memory port
// -----------------------------------------------------------------------------
module nes_mem_arbiter
  import nes_mem_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int AW          = 22,
  parameter int DW          = 8,
  parameter int SLOT_CYCLES = 4,
  parameter int HDR_BYTES   = HDR_BYTES_DEF,
  parameter int CHR_SHIFT   = CHR_SHIFT_DEF
) (
  input  logic            clk,
  input  logic            reset,
  output logic            run_mem,
  output logic            run_nes,
  input  logic            xlat_en,
  input  logic [7:0]      chr_offset,
  input  logic [NCH-1:0]  req_valid,
  output logic [NCH-1:0]  req_ready,
  input  logic [NCH-1:0]  req_write,
  input  logic [NCH*AW-1:0] req_addr,
  input  logic [NCH*DW-1:0] req_wdata,
  output logic [NCH-1:0]  ack,
  output logic [NCH*DW-1:0] rd_data,
  output logic            mem_ce,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_do,
  input  logic [DW-1:0]   mem_di
);

  localparam int PW  = (NCH > 1) ? clog2(NCH) : 1;
  localparam int PHW = (SLOT_CYCLES > 2) ? clog2(SLOT_CYCLES) : 1;
  localparam logic [PHW-1:0] PH_ZERO = {PHW{1'b0}};
  localparam logic [PHW-1:0] PH_LAST = PHW'(SLOT_CYCLES - 1);
  localparam logic [PW-1:0]  PTR_TOP = PW'(NCH - 1);

  if (SLOT_CYCLES < 2 || NCH < 1 || NCH > 8) begin : g_param_check
    $error("nes_mem_arbiter: NCH must be 1..8 and SLOT_CYCLES >= 2");
  end

  // Phase and strobes
  logic [PHW-1:0] r_ph;
  logic           r_run_mem;
  logic           r_run_nes;
  logic [PHW-1:0] w_ph_next;
  logic           w_ph_last;

  // Request slots
  logic [NCH-1:0] r_pending;
  logic [AW-1:0]  r_slot_addr  [NCH];
  logic [DW-1:0]  r_slot_wdata [NCH];
  logic [NCH-1:0] r_slot_write;
  logic [NCH-1:0] w_accept;
  logic [AW-1:0]  w_req_addr   [NCH];
  logic [DW-1:0]  w_req_wdata  [NCH];

  // Arbitration and the slot in flight
  logic [PW-1:0]  r_rr_ptr;
  logic           r_gnt_valid;
  logic [PW-1:0]  r_gnt_idx;
  logic           r_gnt_write;
  logic [NCH-1:0] w_done_mask;
  logic [NCH-1:0] w_arb_req;
  logic [NCH-1:0] w_grant;
  logic [PW-1:0]  w_win;
  logic           w_any;
  logic [AW-1:0]  w_sel_addr;
  logic [DW-1:0]  w_sel_wdata;
  logic           w_sel_write;

  // Registered outputs
  logic [NCH-1:0] r_ack;
  logic [DW-1:0]  r_rd_data [NCH];
  logic           r_mem_ce;
  logic           r_mem_we;
  logic [AW-1:0]  r_mem_addr;
  logic [DW-1:0]  r_mem_do;

  assign w_ph_last = (r_ph == PH_LAST);
  assign w_ph_next = w_ph_last ? PH_ZERO : (r_ph + PHW'(1));
  assign w_accept  = req_valid & ~r_pending;

  // The channel completing this edge still shows pending; keep it out of the
  // arbitration for the next slot.
  assign w_arb_req = (r_pending | w_accept) & ~w_done_mask;

  // Unpack flat request buses into per-channel views
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_req_addr[i]  = req_addr[i*AW +: AW];
      w_req_wdata[i] = req_wdata[i*DW +: DW];
    end
  end

  // One-hot of the channel whose slot completes on this edge
  always_comb begin
    w_done_mask = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_ph_last && r_gnt_valid && (r_gnt_idx == PW'(i))) begin
        w_done_mask[i] = 1'b1;
      end else begin
        w_done_mask[i] = 1'b0;
      end
    end
  end

  nes_rr_arbiter #(
    .NCH (NCH),
    .PW  (PW)
  ) u_rr (
    .i_req       (w_arb_req),
    .i_ptr       (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_win),
    .o_any       (w_any)
  );

  // Winner's request: taken straight from the inputs if accepted this cycle
  always_comb begin
    w_sel_addr  = r_slot_addr[w_win];
    w_sel_wdata = r_slot_wdata[w_win];
    w_sel_write = r_slot_write[w_win];
    if ((w_grant & w_accept) != '0) begin
      w_sel_addr  = w_req_addr[w_win];
      w_sel_wdata = w_req_wdata[w_win];
      w_sel_write = req_write[w_win];
    end else begin
      // winner was latched in an earlier cycle
    end
  end

  // Slot timing: phase counter and the phase strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ph      <= PH_ZERO;
      r_run_mem <= 1'b1;
      r_run_nes <= 1'b0;
    end else begin
      r_ph      <= w_ph_next;
      r_run_mem <= (w_ph_next == PH_ZERO);
      r_run_nes <= (w_ph_next == PH_LAST);
    end
  end

  // Request capture: latch accepted requests, track pending per channel
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending    <= '0;
      r_slot_write <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_slot_addr[i]  <= '0;
        r_slot_wdata[i] <= '0;
      end
    end else begin
      r_pending <= (r_pending | w_accept) & ~w_done_mask;
      for (int i = 0; i < NCH; i++) begin
        if (w_accept[i]) begin
          r_slot_addr[i]  <= w_req_addr[i];
          r_slot_wdata[i] <= w_req_wdata[i];
          r_slot_write[i] <= req_write[i];
        end
      end
    end
  end

  // Issue and completion: both happen on the last-phase edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_gnt_valid <= 1'b0;
      r_gnt_idx   <= '0;
      r_gnt_write <= 1'b0;
      r_ack       <= '0;
      r_mem_ce    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_do    <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_rd_data[i] <= '0;
      end
    end else begin
      // done mask is only non-zero on the last-phase edge -> one-cycle pulse
      r_ack <= w_done_mask;
      for (int i = 0; i < NCH; i++) begin
        if (w_done_mask[i] && !r_gnt_write) begin
          r_rd_data[i] <= mem_di;
        end
      end
      if (w_ph_last) begin
        r_gnt_valid <= w_any;
        r_gnt_idx   <= w_win;
        r_gnt_write <= w_sel_write;
        r_mem_ce    <= w_any;
        r_mem_we    <= w_any & w_sel_write;
        if (w_any) begin
          r_mem_addr <= AW'(nes_xlat(32'(w_sel_addr), chr_offset, xlat_en,
                                     AW, HDR_BYTES, CHR_SHIFT));
          r_mem_do   <= w_sel_wdata;
          r_rr_ptr   <= (w_win == PTR_TOP) ? '0 : (w_win + PW'(1));
        end
      end else begin
        // strobes last for phase 0 only; address and data hold
        r_mem_ce <= 1'b0;
        r_mem_we <= 1'b0;
      end
    end
  end

  assign run_mem   = r_run_mem;
  assign run_nes   = r_run_nes;
  assign req_ready = ~r_pending;
  assign ack       = r_ack;
  assign mem_ce    = r_mem_ce;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_do    = r_mem_do;

  for (genvar g = 0; g < NCH; g++) begin : g_rd_data
    assign rd_data[g*DW +: DW] = r_rd_data[g];
  end

endmodule
